// File: rtl/simmem_resp_bank.sv
// Response bank for the simulated memory controller: shared slot storage, one FIFO-ordered
// linked list per AXI ID, round-robin release of list heads into a registered output stage.
module simmem_resp_bank #(
    parameter int IDWidth   = 4,
    parameter int DataWidth = 3,
    parameter int Capacity  = 32,
    localparam int NumIds    = 2 ** IDWidth,
    localparam int SlotWidth = $clog2(Capacity),
    localparam int CntWidth  = $clog2(Capacity + 1),
    localparam int RespWidth = IDWidth + DataWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [RespWidth-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [NumIds-1:0]    release_en_i,
    output logic [RespWidth-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [NumIds-1:0]    nonempty_o,
    output logic [CntWidth-1:0]  occupancy_o
);

    logic [RespWidth-1:0] mem_data [Capacity];
    logic [SlotWidth-1:0] mem_next [Capacity];
    logic [SlotWidth-1:0] head_q   [NumIds];
    logic [SlotWidth-1:0] tail_q   [NumIds];

    logic [Capacity-1:0]  free_q;
    logic [NumIds-1:0]    nonempty_q;
    logic [CntWidth-1:0]  count_q;
    logic [IDWidth-1:0]   rr_q;
    logic [RespWidth-1:0] out_data_q;
    logic                 out_valid_q;

    logic [IDWidth-1:0]   in_id;
    logic                 push;
    logic [SlotWidth-1:0] alloc;
    logic [NumIds-1:0]    eligible;
    logic [IDWidth-1:0]   grant;
    logic [IDWidth-1:0]   rr_idx;
    logic                 any_eligible;
    logic                 pop;
    logic [SlotWidth-1:0] pop_slot;
    logic                 pop_last;
    logic                 push_onto_popped;

    assign in_id      = in_data_i[RespWidth-1 -: IDWidth];
    assign in_ready_o = |free_q;
    assign push       = in_valid_i && in_ready_o;
    assign eligible   = nonempty_q & release_en_i;

    // Lowest-index free slot; later iterations win, so the loop runs downward.
    always_comb begin
        alloc = '0;
        for (int i = Capacity - 1; i >= 0; i--) begin
            if (free_q[i]) alloc = SlotWidth'(i);
        end
    end

    // Round-robin search starting at rr_q; smallest offset from rr_q wins.
    always_comb begin
        grant        = rr_q;
        rr_idx       = '0;
        any_eligible = 1'b0;
        for (int i = NumIds - 1; i >= 0; i--) begin
            rr_idx = rr_q + IDWidth'(i);
            if (eligible[rr_idx]) begin
                grant        = rr_idx;
                any_eligible = 1'b1;
            end
        end
    end

    assign pop      = (!out_valid_q || out_ready_i) && any_eligible;
    assign pop_slot = head_q[grant];
    assign pop_last = (head_q[grant] == tail_q[grant]);
    // Push onto a single-entry list that is being popped this cycle: the new slot starts a fresh list.
    assign push_onto_popped = pop && pop_last && (grant == in_id);

    // Storage and list pointers carry no reset; nonempty_q alone decides whether they are meaningful.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[alloc] <= in_data_i;
            tail_q[in_id]   <= alloc;
            if (nonempty_q[in_id] && !push_onto_popped) mem_next[tail_q[in_id]] <= alloc;
        end
        if (pop) head_q[grant] <= mem_next[pop_slot];
        if (push && (!nonempty_q[in_id] || push_onto_popped)) head_q[in_id] <= alloc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            free_q      <= '1;
            nonempty_q  <= '0;
            count_q     <= '0;
            rr_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (pop) free_q[pop_slot] <= 1'b1;
            if (push) free_q[alloc] <= 1'b0;

            if (pop && pop_last) nonempty_q[grant] <= 1'b0;
            if (push) nonempty_q[in_id] <= 1'b1;

            count_q <= count_q + CntWidth'(push) - CntWidth'(pop);

            if (pop) begin
                out_data_q  <= mem_data[pop_slot];
                out_valid_q <= 1'b1;
                rr_q        <= grant + IDWidth'(1);
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign nonempty_o  = nonempty_q;
    assign occupancy_o = count_q;

endmodule

// File: doc/simmem_resp_bank.md
# simmem_resp_bank

Parametrised response bank for the simulated memory controller. Stores AXI responses (write responses or read data beats) returned by the real memory in a shared storage of `Capacity` slots, keeps one FIFO-ordered linked list per AXI ID, and emits the head of an ID's list only when the delay logic releases that ID. Generalises the fixed 32-entry write-response and read-data banks: one block, instantiated once per response channel, with configurable payload width, ID width and depth, and round-robin arbitration across released IDs.

## Interface
- `IDWidth`, default 4: AXI ID width; `NumIds = 2**IDWidth` derived.
- `DataWidth`, default 3: payload width excluding ID (3 = write response content; 37 = read data + resp + last).
- `Capacity`, default 32: storage slots, ≥2; `SlotWidth = $clog2(Capacity)`.
- `clk_i  in  1  clock`
- `rst_i  in  1  reset, asynchronous, active-high`
- `in_data_i  in  IDWidth+DataWidth  response from memory; ID in MSBs ({id, payload}, same packing as write_resp_t)`
- `in_valid_i  in  1  input valid`
- `in_ready_o  out  1  input ready; high iff ≥1 free slot`
- `release_en_i  in  NumIds  per-ID release permission from delay logic`
- `out_data_o  out  IDWidth+DataWidth  released response, registered`
- `out_valid_o  out  1  output valid, registered`
- `out_ready_i  in  1  output ready`
- `nonempty_o  out  NumIds  per-ID "list holds ≥1 stored response"`
- `occupancy_o  out  $clog2(Capacity+1)  slots in use (excludes output register)`

## Operation
- Storage: `Capacity` entries of {payload+ID, next pointer}; free-slot bitmap; per-ID head, tail, nonempty registers; one output register.
- Push (in_valid_i && in_ready_o): allocate lowest-index free slot per bitmap at cycle start; write entry; if ID list empty, head=tail=slot; else next[tail]=slot, tail=slot. Same-ID order strictly preserved.
- Eligibility: ID eligible iff nonempty (registered state, cycle start) && release_en_i[id].
- Load condition: output register empty or being drained (out_valid_o && out_ready_i) and ≥1 eligible ID.
- Round-robin: pointer rr_q; grant first eligible ID at index ≥ rr_q, wrapping; then rr_q = (grant+1) mod NumIds.
- Pop: output register ← entry[head[grant]]; free that slot; head ← next[head]; if head==tail, clear nonempty.
- Simultaneous push and pop, same ID, list of 1: pop old head, new slot becomes head and tail, nonempty stays 1.
- Push to empty list is not poppable in the same cycle.
- Slot freed by a pop is not reallocated in that cycle.
- Simultaneous push and pop: occupancy_o unchanged.
- Full (occupancy == Capacity): in_ready_o = 0, in_data_i ignored; pop still allowed, in_ready_o returns high next cycle.
- Output register obeys AXI: while out_valid_o && !out_ready_i, out_data_o stable; release_en_i deassertion does not retract a loaded response.
- Reset (any time, mid-burst included): all lists, bitmap, rr_q and output register cleared; content discarded.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, in_ready_o=1, nonempty_o=0, occupancy_o=0, rr_q=0.
- in_ready_o, nonempty_o and occupancy_o are functions of registers only (no combinational path from in/out valid/ready).
- Push handshake at cycle N → nonempty_o[id]=1 and occupancy +1 at N+1.
- Eligible at N+1 → out_valid_o=1 at N+2 (minimum store-to-output latency 2).
- Continuous out_ready_i with eligible IDs → one response per cycle, no bubbles.
- out_ready_i=0 while valid → no pop, lists unchanged.

## Test plan
- Reset then single push {id=3, payload=5}, release_en_i=16'h0008 → nonempty_o=16'h0008 at N+1, out_data_o={3,5}, out_valid_o at N+2; occupancy back to 0 after handshake.
- Push id 2 payloads 1,2,3, release id 2, out_ready_i=1 → outputs 1,2,3 on consecutive cycles in order.
- Push one response each on ids 0,1,2, release 16'h0007, out_ready_i=1 → grant order 0,1,2; then repeat with rr_q=3 → order 0,1,2 again; with ids 1,2 stored after rr_q=2 → 2 then 1.
- Fill 32 slots with release_en_i=0 → in_ready_o=0, occupancy_o=32, extra input not stored; release one ID, pop once → in_ready_o=1 next cycle.
- Hold out_ready_i=0 with out_valid_o=1, toggle release_en_i and push more → out_data_o stable, no pops; raise out_ready_i → drain correct.
- Assert rst_i mid-drain with 10 stored → next cycle all outputs at reset values; subsequent push/pop behaves as from clean state.
